// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp32_pkg
// Brief  : Shared IEEE-754 binary32 constants, field widths, the
//          sign/exponent/mantissa struct and a leading-zero-count helper
//          used by the accumulating BRAM and its adder.
// Rev    : 1.0  initial release
// ============================================================================
package fp32_pkg;

    localparam int DATA_W   = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int SIG_W    = MAN_W + 1;
    localparam int EXP_BIAS = 127;

    localparam logic [DATA_W-1:0] FP32_QNAN     = 32'h7FC0_0000;
    localparam logic [DATA_W-1:0] FP32_POS_INF  = 32'h7F80_0000;
    localparam logic [DATA_W-1:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [DATA_W-1:0] FP32_NEG_ZERO = 32'h8000_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    // Leading-zero count of a 27-bit working significand (27 when all zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic found;
        lzc27 = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    lzc27 = lzc27 + 5'd1;
                end
            end
        end
    endfunction

endpackage : fp32_pkg
`default_nettype wire

// File: rtl/fp32_accum_bram_if.sv
`default_nettype none
// ============================================================================
// Module : fp32_accum_bram_if
// Brief  : Port bundle of the accumulating BRAM.
//          ena/wea/addra/dina/add_b : master -> slave (request side)
//          douta/add_result         : slave  -> master (read data and sum)
// Rev    : 1.0  initial release
// ============================================================================
interface fp32_accum_bram_if;
    import fp32_pkg::*;

    logic              ena;
    logic              wea;
    logic [31:0]       addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_result;

    modport master (
        output ena, wea, addra, dina, add_b,
        input  douta, add_result
    );

    modport slave (
        input  ena, wea, addra, dina, add_b,
        output douta, add_result
    );

endinterface : fp32_accum_bram_if
`default_nettype wire

// File: rtl/fp32_add_core.sv
`default_nettype none
// ============================================================================
// Module : fp32_add_core
// Brief  : Combinational IEEE-754 binary32 adder, round-to-nearest-even.
//          Denormal inputs read as signed zero, denormal results flush to +0.
// Ports  : a, b   (in,  32) operands
//          result (out, 32) a + b
// Rev    : 1.0  initial release
// ============================================================================
module fp32_add_core
    import fp32_pkg::*;
(
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    output logic      [DATA_W-1:0] result
);

    fp32_t w_a;
    fp32_t w_b;
    assign w_a = a;
    assign w_b = b;

    // ---- operand classification -------------------------------------------
    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    assign w_a_nan  = (w_a.exp == 8'hFF) && (w_a.man != '0);
    assign w_b_nan  = (w_b.exp == 8'hFF) && (w_b.man != '0);
    assign w_a_inf  = (w_a.exp == 8'hFF) && (w_a.man == '0);
    assign w_b_inf  = (w_b.exp == 8'hFF) && (w_b.man == '0);
    assign w_a_zero = (w_a.exp == 8'h00);
    assign w_b_zero = (w_b.exp == 8'h00);

    // ---- order by magnitude so the subtraction never goes negative --------
    logic  w_swap;
    fp32_t w_big;
    fp32_t w_small;
    assign w_swap  = {w_b.exp, w_b.man} > {w_a.exp, w_a.man};
    assign w_big   = w_swap ? w_b : w_a;
    assign w_small = w_swap ? w_a : w_b;

    logic [EXP_W-1:0] w_diff;
    assign w_diff = w_big.exp - w_small.exp;

    // ---- alignment: 24-bit significand + guard, round, sticky -------------
    logic [49:0] w_small_ext;
    logic [26:0] w_big_al;
    logic [26:0] w_small_al;
    assign w_small_ext = {1'b1, w_small.man, 26'd0} >> w_diff;
    assign w_small_al  = {w_small_ext[49:24], |w_small_ext[23:0]};
    assign w_big_al    = {1'b1, w_big.man, 3'b000};

    logic [27:0] w_sum;
    assign w_sum = (w_big.sign == w_small.sign) ? ({1'b0, w_big_al} + {1'b0, w_small_al})
                                                : ({1'b0, w_big_al} - {1'b0, w_small_al});

    // ---- normalise, round, pack -------------------------------------------
    logic [4:0]        w_lz;
    logic [26:0]       w_norm;
    logic signed [9:0] w_exp_norm;
    logic              w_round_up;
    logic [23:0]       w_frac_rnd;
    logic signed [9:0] w_exp_final;
    logic [DATA_W-1:0] w_general;

    always_comb begin
        w_lz        = lzc27(w_sum[26:0]);
        w_norm      = '0;
        w_exp_norm  = '0;
        w_round_up  = 1'b0;
        w_frac_rnd  = '0;
        w_exp_final = '0;
        w_general   = FP32_POS_ZERO;

        if (w_sum[27]) begin
            // Carry out: one-bit right shift, folding the lost bit into sticky.
            w_norm     = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp_norm = $signed({2'b00, w_big.exp}) + 10'sd1;
        end else begin
            // A left shift of 2+ only happens for near-equal exponents, where
            // the difference is exact, so shifting zeros into G/R/S is safe.
            w_norm     = w_sum[26:0] << w_lz;
            w_exp_norm = $signed({2'b00, w_big.exp}) - $signed({5'd0, w_lz});
        end

        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        // Fraction carry (bit 23) means 1.111..1 rounded up to 10.000..0.
        w_frac_rnd  = {1'b0, w_norm[25:3]} + {23'd0, w_round_up};
        w_exp_final = w_frac_rnd[23] ? (w_exp_norm + 10'sd1) : w_exp_norm;

        if (!w_norm[26]) begin
            w_general = FP32_POS_ZERO;                 // exact cancellation
        end else if (w_exp_norm <= 10'sd0) begin
            w_general = FP32_POS_ZERO;                 // would be denormal
        end else if (w_exp_final >= 10'sd255) begin
            w_general = {w_big.sign, FP32_POS_INF[30:0]};
        end else begin
            w_general = {w_big.sign, w_exp_final[7:0], w_frac_rnd[22:0]};
        end
    end

    // ---- special-case priority --------------------------------------------
    always_comb begin
        result = w_general;
        if (w_a_nan || w_b_nan) begin
            result = FP32_QNAN;
        end else if (w_a_inf && w_b_inf && (w_a.sign != w_b.sign)) begin
            result = FP32_QNAN;
        end else if (w_a_inf) begin
            result = a;
        end else if (w_b_inf) begin
            result = b;
        end else if (w_a_zero && w_b_zero) begin
            result = (w_a.sign && w_b.sign) ? FP32_NEG_ZERO : FP32_POS_ZERO;
        end else if (w_a_zero) begin
            result = b;
        end else if (w_b_zero) begin
            result = a;
        end else if (w_diff > 8'd25) begin
            // Smaller operand is below a quarter ULP: rounding cannot move us.
            result = w_big;
        end
    end

endmodule : fp32_add_core
`default_nettype wire

// File: rtl/fp32_accum_bram.sv
`default_nettype none
// ============================================================================
// Module : fp32_accum_bram
// Brief  : Single-port DEPTH x 32 block RAM with a combinational fp32 adder
//          whose A operand is the registered read port. Supports read-add-
//          write accumulation of pulse shapes into a buffer.
// Ports  : clka        (in)  clock
//          rsta        (in)  synchronous active-high reset (clears douta only)
//          bus.slave   ena/wea/addra/dina/add_b in, douta/add_result out
//                      addra is a byte address; word index = addra[AW+1:2]
// Rev    : 1.0  initial release
// ============================================================================
module fp32_accum_bram
    import fp32_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
)(
    input  wire logic         clka,
    input  wire logic         rsta,
    fp32_accum_bram_if.slave  bus
);

    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] r_douta;
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_add_result;

    // Bits above AW+1 are dropped, giving modulo-DEPTH wrap.
    assign w_idx = bus.addra[AW+1:2];

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clka) begin
        if (!rsta && bus.ena && bus.wea) begin
            r_mem[w_idx] <= bus.dina;
        end
    end

    // Write-first read port; holds while disabled so a read-wait-write
    // sequence can still use the value two cycles after the read.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_douta <= '0;
        end else if (bus.ena) begin
            if (bus.wea) begin
                r_douta <= bus.dina;
            end else begin
                r_douta <= r_mem[w_idx];
            end
        end
    end

    fp32_add_core u_add (
        .a      (r_douta),
        .b      (bus.add_b),
        .result (w_add_result)
    );

    assign bus.douta      = r_douta;
    assign bus.add_result = w_add_result;

endmodule : fp32_accum_bram
`default_nettype wire

// File: tb/tb_fp32_accum_bram.sv
`default_nettype none
// ============================================================================
// Module : tb_fp32_accum_bram
// Brief  : Directed self-checking bench for fp32_accum_bram.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fp32_accum_bram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp32_accum_bram_if bus();

    fp32_accum_bram #(.DEPTH(2048), .AW(11)) dut (
        .clka (clk),
        .rsta (rst),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.ena   = en;
        bus.wea   = we;
        bus.addra = addr;
        bus.dina  = data;
        step();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b1, addr, data);
    endtask

    task automatic rd(input logic [31:0] addr);
        drive(1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        // Reset with a write request present: it must be ignored.
        rst = 1'b1;
        bus.add_b = 32'h0;
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 32'h40; bus.dina = 32'hDEAD_BEEF;
        step();
        step();
        checks++;
        if (bus.douta !== 32'h0) begin
            errors++;
            $display("FAIL reset_douta got %08h want 00000000", bus.douta);
        end
        rst = 1'b0;
        rd(32'h40);
        checks++;
        if (bus.douta !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_write got %08h want 00000000", bus.douta);
        end
    endtask

    task automatic test_write_read();
        wr(32'h10, 32'h3DA3_39C1);
        checks++;
        if (bus.douta !== 32'h3DA3_39C1) begin
            errors++;
            $display("FAIL write_first got %08h want 3da339c1", bus.douta);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (bus.douta !== 32'h3DA3_39C1) begin
                errors++;
                $display("FAIL idle_hold[%0d] got %08h want 3da339c1", i, bus.douta);
            end
        end
        rd(32'h40);
        checks++;
        if (bus.douta !== 32'h0) begin
            errors++;
            $display("FAIL read_zero got %08h want 00000000", bus.douta);
        end
        rd(32'h2010);
        checks++;
        if (bus.douta !== 32'h3DA3_39C1) begin
            errors++;
            $display("FAIL addr_wrap got %08h want 3da339c1", bus.douta);
        end
        rd(32'h44);
        rd(32'h13);
        checks++;
        if (bus.douta !== 32'h3DA3_39C1) begin
            errors++;
            $display("FAIL addr_unaligned got %08h want 3da339c1", bus.douta);
        end
    endtask

    task automatic test_accumulate();
        logic [31:0] sum;
        wr(32'h10, 32'h3FC0_0000);
        rd(32'h40);
        rd(32'h10);
        checks++;
        if (bus.douta !== 32'h3FC0_0000) begin
            errors++;
            $display("FAIL accum_read got %08h want 3fc00000", bus.douta);
        end
        idle();
        bus.add_b = 32'h4010_0000;
        #1;
        checks++;
        if (bus.add_result !== 32'h4070_0000) begin
            errors++;
            $display("FAIL accum_sum got %08h want 40700000", bus.add_result);
        end
        sum = bus.add_result;
        wr(32'h10, sum);
        rd(32'h44);
        rd(32'h10);
        checks++;
        if (bus.douta !== 32'h4070_0000) begin
            errors++;
            $display("FAIL accum_writeback got %08h want 40700000", bus.douta);
        end
    endtask

    task automatic test_adder();
        logic [31:0] va [17];
        logic [31:0] vb [17];
        logic [31:0] ve [17];
        va = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F800000,
               32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h00000001, 32'h80000000,
               32'hFF800000, 32'h3F800000, 32'h3F800001, 32'h4B800000, 32'h3F800000,
               32'h00800001, 32'hC0000000};
        vb = '{32'h3F800000, 32'hBF800000, 32'h3DA339C1, 32'h33800000, 32'h34400000,
               32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h00000001, 32'h80000000,
               32'h3F800000, 32'hBF000000, 32'h3F800002, 32'h3F800000, 32'h32000000,
               32'h80800000, 32'h3F800000};
        ve = '{32'h40000000, 32'h00000000, 32'h3DA339C1, 32'h3F800000, 32'h3F800002,
               32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h80000000,
               32'hFF800000, 32'h3F000000, 32'h40000002, 32'h4B800000, 32'h3F800000,
               32'h00000000, 32'hBF800000};
        for (int i = 0; i < 17; i++) begin
            wr(32'h100, va[i]);
            bus.ena   = 1'b0;
            bus.add_b = vb[i];
            #1;
            checks++;
            if (bus.add_result !== ve[i]) begin
                errors++;
                $display("FAIL adder[%0d] %08h+%08h got %08h want %08h",
                         i, va[i], vb[i], bus.add_result, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h200, 32'h204, 32'h208};
        datas = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        for (int i = 0; i < 3; i++) begin
            wr(addrs[i], datas[i]);
            checks++;
            if (bus.douta !== datas[i]) begin
                errors++;
                $display("FAIL b2b_write[%0d] got %08h want %08h", i, bus.douta, datas[i]);
            end
        end
        for (int i = 2; i >= 0; i--) begin
            rd(addrs[i]);
            checks++;
            if (bus.douta !== datas[i]) begin
                errors++;
                $display("FAIL b2b_read[%0d] got %08h want %08h", i, bus.douta, datas[i]);
            end
        end
        // Reset clears the output register but not the array.
        rst = 1'b1;
        step();
        checks++;
        if (bus.douta !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset got %08h want 00000000", bus.douta);
        end
        rst = 1'b0;
        rd(32'h204);
        checks++;
        if (bus.douta !== 32'h2222_2222) begin
            errors++;
            $display("FAIL mem_kept got %08h want 22222222", bus.douta);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_accumulate();
        test_adder();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_fp32_accum_bram
`default_nettype wire

// File: doc/fp32_accum_bram.md
Name: fp32_accum_bram

Overview:
- Single-port 32-bit block RAM with an integrated combinational IEEE-754 single-precision adder.
- The adder's A operand is the RAM read port (douta); its B operand is an external input (add_b).
- Used by the pulse generator for read–add–write accumulation of neutron pulse shapes into a pulse buffer.
- Memory is byte-addressed on the port side and word-organised internally.

Parameters:
- DEPTH, 2048, number of 32-bit words. Must be a power of two.
- AW, 11, word-index width (log2 DEPTH).

Ports:
- clka  input  1  clock; all state updates on rising edge.
- rsta  input  1  synchronous active-high reset.
- ena  input  1  port enable; no read or write when low.
- wea  input  1  write enable; qualified by ena.
- addra  input  32  byte address; word index = addra[AW+1:2]; bits [1:0] and above AW+1 ignored.
- dina  input  32  write data.
- douta  output  32  registered read data.
- add_b  input  32  fp32 B operand.
- add_result  output  32  combinational fp32 sum of douta and add_b.

Behaviour:
- Memory array: DEPTH×32, initialised to all zeros at configuration/simulation start. rsta does not clear memory contents.
- Reset: when rsta=1 at a clock edge:
  - douta <= 0.
  - No write occurs, regardless of ena/wea.
- Read (ena=1, wea=0): douta <= mem[idx] at the edge; 1-cycle latency.
- Write (ena=1, wea=1): mem[idx] <= dina; douta <= dina in the same edge (write-first).
- Idle (ena=0): douta holds its last value indefinitely. This lets a read–wait–write sequence use douta two cycles after the read.
- Address handling: out-of-range bytes wrap modulo DEPTH through bit truncation. Unaligned addresses access the containing word.
- add_result: purely combinational from douta and add_b; zero cycle latency; no reset dependence other than douta.
- Adder arithmetic, IEEE-754 binary32:
  - Align the smaller operand by exponent difference, keeping guard, round and sticky bits.
  - Add or subtract significands by sign, normalise (left shift via leading-zero count, or 1-bit right shift on carry).
  - Round to nearest, ties to even.
  - Denormal inputs are treated as signed zero; denormal results flush to +0.
- Adder special cases:
  - Either operand NaN -> 0x7FC00000.
  - +Inf + -Inf -> 0x7FC00000.
  - Inf + finite -> that Inf.
  - Exponent overflow after rounding -> signed Inf.
  - Exact zero result -> +0, except (-0)+(-0) -> -0.
  - Exponent difference > 25 -> larger operand returned unchanged (after the rounding check).

Decomposition:
- Shared package fp32_pkg holds constants: FP32_QNAN=0x7FC00000, FP32_POS_INF=0x7F800000, EXP_BIAS=127, field widths, and a sign/exponent/mantissa struct typedef.
- One sub-module, fp32_add_core (combinational a, b -> result), instantiated once with a=douta and b=add_b.
- RAM storage stays in the top module.

Test Plan:
- Reset then read: rsta=1 for 2 cycles -> douta=0. Read addra=0x40 -> douta=0x00000000 one cycle later (zero init).
- Write/read plus address wrap:
  - Write 0x3DA339C1 at addra=0x10; next cycle douta=0x3DA339C1 (write-first).
  - ena=0 for 3 cycles -> douta unchanged.
  - Read addra=0x2010 (wraps to word 4) -> 0x3DA339C1.
- Accumulate sequence: read word 4 (0x3FC00000), idle one cycle, add_b=0x40100000 -> add_result=0x40700000. Write it back; re-read -> 0x40700000.
- Adder basics (douta loaded via write):
  - 0x3F800000 + 0x3F800000 -> 0x40000000.
  - 0x3F800000 + 0xBF800000 -> 0x00000000.
  - 0 + 0x3DA339C1 -> 0x3DA339C1.
- Rounding:
  - 0x3F800000 + 0x33800000 (exact tie) -> 0x3F800000.
  - 0x3F800000 + 0x34400000 -> 0x3F800002.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
  - Denormal 0x00000001 + 0x00000001 -> 0x00000000.
